commit_instr_queue: RTL and testbench
=====================================

Name: commit_instr_queue

Overview:
- Buffers instructions retired on the CVA6 commit ports (up to NR_COMMIT_PORTS per cycle) and serialises them into a single valid/ready stream, one instruction per cycle.
- The stream feeds riscv_decoder's instr_i.
- Each entry is tagged with its PC and a monotonically increasing sequence number.
- Overflow is flagged and counted; entries are never silently reordered.

Parameters:
- NR_COMMIT_PORTS, 2, number of commit ports sampled per cycle (1 or 2 supported).
- DEPTH, 8, queue entries; power of two, >= 2.
- XLEN, 64, PC width.
- SEQ_W, 32, sequence-number width.
- DROP_W, 16, dropped-instruction counter width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous queue clear
- commit_valid_i  in  NR_COMMIT_PORTS  per-port retire strobe
- commit_instr_i  in  NR_COMMIT_PORTS x 32  retired instruction word
- commit_pc_i  in  NR_COMMIT_PORTS x XLEN  retired PC
- out_valid_o  out  1  head entry available
- out_ready_i  in  1  consumer accepts head
- out_instr_o  out  32  head instruction, to riscv_decoder instr_i
- out_pc_o  out  XLEN  head PC
- out_seq_o  out  SEQ_W  head sequence number
- count_o  out  clog2(DEPTH)+1  current occupancy
- overflow_o  out  1  sticky: at least one retire was dropped
- drop_cnt_o  out  DROP_W  dropped retires, saturating

Behaviour:
- Reset: clocked on clk_i; rst_ni is asynchronous, active-low. All outputs go to 0, with out_valid_o=0 and count_o=0; pointers and seq counter are 0. Reset mid-operation discards all entries immediately.
- Storage: circular buffer with head/tail pointers of clog2(DEPTH) bits that wrap modulo DEPTH. count is tracked separately so full (count==DEPTH) and empty (count==0) are unambiguous.
- Pop: occurs when out_valid_o && out_ready_i. Head advances and count decrements at the clock edge.
- Push order: valid ports are processed in ascending port index. Invalid ports are skipped, so port1 valid with port0 invalid enqueues port1 alone.
- Space this cycle is DEPTH - count + pop. A pop in the same cycle frees its slot for pushes.
- Ports that do not fit are dropped. A later port can never be accepted when an earlier port was dropped.
- Each dropped retire sets overflow_o and increments drop_cnt_o, saturating at all-ones.
- Seq tagging: each accepted entry takes the current seq value, then seq increments (port0 gets n, port1 gets n+1). Seq wraps modulo 2^SEQ_W. Dropped retires consume no sequence number.
- Latency: an entry pushed in cycle t is visible at the outputs in cycle t+1. There is no combinational bypass from commit inputs to outputs.
- out_valid_o = (count != 0).
- Outputs are driven directly from the head entry. While out_valid_o && !out_ready_i, the out_* data holds stable.
- Empty queue: out_valid_o=0 and out_* data shows the stale head slot. Consumers ignore data when out_valid_o=0.
- Flush: when flush_i=1, the next cycle has count=0 and out_valid_o=0, and overflow_o is cleared.
  - Any push or pop in the flush cycle is discarded and does not touch drop_cnt_o.
  - The seq counter and drop_cnt_o are preserved across flush.
- count_o is registered, reflects the post-edge state, and never exceeds DEPTH.

Decomposition:
- commit_queue_pkg holds:
  - typedef commit_entry_t {instr[31:0], pc[XLEN-1:0], seq[SEQ_W-1:0]}
  - constant PTR_W = clog2(DEPTH)
  - helper function for the saturating increment
- One sub-module, commit_queue_mem: a DEPTH x commit_entry_t register array with up to NR_COMMIT_PORTS write ports and one asynchronous read port at head.
- Pointer, count, seq and drop logic stays in the top-level block.

Test Plan:
- Single push: reset, then port0 valid with instr 0x00500093 and pc 0x80000000, out_ready=1. Next cycle out_valid=1, out_instr=0x00500093, out_seq=0, count=1; the cycle after, count=0.
- Dual push, ordering: port0 0x00000013 and port1 0x00100113 in the same cycle, out_ready=0. Head shows seq0/0x00000013. After a pop, the head is seq1/0x00100113 with count=1.
- Overflow: out_ready=0; fill 8 entries; then dual push. Both dropped, drop_cnt=2, overflow=1, count=8. Same-cycle pop with a dual push at count=8 accepts only port0.
- Pointer wrap and backpressure: stream 20 single pushes with out_ready toggling every cycle. Output seq runs 0..19 in order with no loss, and data holds stable whenever valid=1 and ready=0.
- Flush: with count=5, assert flush with a simultaneous port0 push. Next cycle count=0, out_valid=0, overflow=0. The following push gets the next unused seq value.
- Async reset: deassert rst_ni mid-stream, between clock edges. Outputs go to 0 immediately, and after release the first push gets seq=0.

Source files
------------

// File: rtl/commit_queue_pkg.sv
// Shared types and constants for the commit instruction queue.
// Serialises CVA6 commit-port retires into one stream for riscv_decoder.
package commit_queue_pkg;

    localparam int CQ_DEPTH  = 8;
    localparam int CQ_XLEN   = 64;
    localparam int CQ_SEQ_W  = 32;
    localparam int CQ_DROP_W = 16;
    localparam int PTR_W     = $clog2(CQ_DEPTH);

    typedef struct packed {
        logic [31:0]         instr;
        logic [CQ_XLEN-1:0]  pc;
        logic [CQ_SEQ_W-1:0] seq;
    } commit_entry_t;

    // Adds up to three drops to the counter, sticking at all-ones.
    function automatic logic [CQ_DROP_W-1:0] sat_add(input logic [CQ_DROP_W-1:0] v,
                                                      input logic [1:0] n);
        logic [CQ_DROP_W:0] s;
        s = {1'b0, v} + {{(CQ_DROP_W-1){1'b0}}, n};
        return s[CQ_DROP_W] ? '1 : s[CQ_DROP_W-1:0];
    endfunction

endpackage

// File: rtl/commit_queue_mem.sv
// Entry storage: multi-write register array with an asynchronous read at head.
// Reset clears every slot so stale-head data reads as zero after reset.
module commit_queue_mem
    import commit_queue_pkg::*;
#(
    parameter int DEPTH    = CQ_DEPTH,
    parameter int NR_PORTS = 2,
    parameter int AW       = PTR_W
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NR_PORTS-1:0]           we,
    input  logic [NR_PORTS-1:0][AW-1:0]   waddr,
    input  commit_entry_t [NR_PORTS-1:0]  wdata,
    input  logic [AW-1:0]                 raddr,
    output commit_entry_t                 rdata
);

    commit_entry_t mem_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            for (int p = 0; p < NR_PORTS; p++)
                if (we[p]) mem_q[waddr[p]] <= wdata[p];
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/commit_instr_queue.sv
// Commit-port retire queue: in-order push of up to NR_COMMIT_PORTS per cycle,
// one pop per cycle, seq tagging and saturating drop accounting.
module commit_instr_queue
    import commit_queue_pkg::*;
#(
    parameter int NR_COMMIT_PORTS = 2,
    parameter int DEPTH           = CQ_DEPTH,
    parameter int XLEN            = CQ_XLEN,
    parameter int SEQ_W           = CQ_SEQ_W,
    parameter int DROP_W          = CQ_DROP_W
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  flush_i,
    input  logic [NR_COMMIT_PORTS-1:0]            commit_valid_i,
    input  logic [NR_COMMIT_PORTS-1:0][31:0]      commit_instr_i,
    input  logic [NR_COMMIT_PORTS-1:0][XLEN-1:0]  commit_pc_i,
    output logic                                  out_valid_o,
    input  logic                                  out_ready_i,
    output logic [31:0]                           out_instr_o,
    output logic [XLEN-1:0]                       out_pc_o,
    output logic [SEQ_W-1:0]                      out_seq_o,
    output logic [$clog2(DEPTH):0]                count_o,
    output logic                                  overflow_o,
    output logic [DROP_W-1:0]                     drop_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]     head_q, tail_q;
    logic [CW-1:0]     count_q;
    logic [SEQ_W-1:0]  seq_q;
    logic [DROP_W-1:0] drop_q;
    logic              ovf_q;

    logic                                 pop;
    logic [CW-1:0]                        space, n_acc;
    logic [1:0]                           n_drop;
    logic [NR_COMMIT_PORTS-1:0]           acc;
    logic [NR_COMMIT_PORTS-1:0][AW-1:0]   waddr;
    commit_entry_t [NR_COMMIT_PORTS-1:0]  wdata;
    commit_entry_t                        head_e;

    // Ports fill in ascending order; once one is dropped every later one is too.
    always_comb begin
        pop    = (count_q != '0) && out_ready_i;
        space  = CW'(DEPTH) - count_q + CW'(pop);
        n_acc  = '0;
        n_drop = '0;
        acc    = '0;
        waddr  = '0;
        wdata  = '0;
        for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
            waddr[p] = tail_q + AW'(n_acc);
            wdata[p] = '{instr: commit_instr_i[p], pc: commit_pc_i[p],
                         seq: seq_q + SEQ_W'(n_acc)};
            if (commit_valid_i[p]) begin
                if (n_drop == '0 && n_acc < space) begin
                    acc[p] = 1'b1;
                    n_acc  = n_acc + CW'(1);
                end else begin
                    n_drop = n_drop + 2'd1;
                end
            end
        end
    end

    commit_queue_mem #(.DEPTH(DEPTH), .NR_PORTS(NR_COMMIT_PORTS), .AW(AW)) u_mem (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .we    (acc & {NR_COMMIT_PORTS{!flush_i}}),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (head_q),
        .rdata (head_e)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            seq_q   <= '0;
            drop_q  <= '0;
            ovf_q   <= 1'b0;
        end else if (flush_i) begin
            // seq and drop count survive a flush; same-cycle traffic is discarded
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (pop) head_q <= head_q + AW'(1);
            tail_q  <= tail_q + AW'(n_acc);
            count_q <= count_q + n_acc - CW'(pop);
            seq_q   <= seq_q + SEQ_W'(n_acc);
            if (n_drop != '0) begin
                ovf_q  <= 1'b1;
                drop_q <= sat_add(drop_q, n_drop);
            end
        end
    end

    assign out_valid_o = (count_q != '0);
    assign out_instr_o = head_e.instr;
    assign out_pc_o    = head_e.pc;
    assign out_seq_o   = head_e.seq;
    assign count_o     = count_q;
    assign overflow_o  = ovf_q;
    assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_commit_instr_queue.sv
// Directed bench for commit_instr_queue: ordering, overflow, wrap, flush, reset.
module tb_commit_instr_queue;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              flush_i = 1'b0;
    logic [1:0]        commit_valid_i = '0;
    logic [1:0][31:0]  commit_instr_i = '0;
    logic [1:0][63:0]  commit_pc_i = '0;
    logic              out_valid_o;
    logic              out_ready_i = 1'b0;
    logic [31:0]       out_instr_o;
    logic [63:0]       out_pc_o;
    logic [31:0]       out_seq_o;
    logic [3:0]        count_o;
    logic              overflow_o;
    logic [15:0]       drop_cnt_o;

    int total = 0;
    int bad = 0;

    commit_instr_queue dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .commit_valid_i(commit_valid_i), .commit_instr_i(commit_instr_i),
        .commit_pc_i(commit_pc_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_instr_o(out_instr_o), .out_pc_o(out_pc_o), .out_seq_o(out_seq_o),
        .count_o(count_o), .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [31:0] i0,
                         input logic v1, input logic [31:0] i1);
        commit_valid_i    = {v1, v0};
        commit_instr_i[0] = i0;
        commit_instr_i[1] = i1;
        commit_pc_i[0]    = 64'h8000_0000 + 64'(i0[11:0]);
        commit_pc_i[1]    = 64'h8000_0004 + 64'(i1[11:0]);
    endtask

    initial begin
        int got, exp_seq;
        logic pv, pr;
        logic [31:0] ps, pi;

        // reset state
        drive(0, 0, 0, 0);
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_valid", 64'(out_valid_o), 0);
        chk("rst_count", 64'(count_o), 0);
        chk("rst_ovf", 64'(overflow_o), 0);
        chk("rst_drop", 64'(drop_cnt_o), 0);
        chk("rst_instr", 64'(out_instr_o), 0);
        chk("rst_seq", 64'(out_seq_o), 0);
        rst_ni = 1'b1;

        // single push
        drive(1, 32'h0050_0093, 0, 0);
        commit_pc_i[0] = 64'h8000_0000;
        out_ready_i = 1'b1;
        step();
        drive(0, 0, 0, 0);
        chk("s_valid", 64'(out_valid_o), 1);
        chk("s_instr", 64'(out_instr_o), 64'h0050_0093);
        chk("s_pc", out_pc_o, 64'h8000_0000);
        chk("s_seq", 64'(out_seq_o), 0);
        chk("s_count", 64'(count_o), 1);
        step();
        chk("s_count_after", 64'(count_o), 0);
        chk("s_valid_after", 64'(out_valid_o), 0);

        // dual push ordering (seq 1, 2)
        out_ready_i = 1'b0;
        drive(1, 32'h0000_0013, 1, 32'h0010_0113);
        step();
        drive(0, 0, 0, 0);
        chk("d_count", 64'(count_o), 2);
        chk("d_seq0", 64'(out_seq_o), 1);
        chk("d_instr0", 64'(out_instr_o), 64'h0000_0013);
        out_ready_i = 1'b1;
        step();
        chk("d_count1", 64'(count_o), 1);
        chk("d_seq1", 64'(out_seq_o), 2);
        chk("d_instr1", 64'(out_instr_o), 64'h0010_0113);
        step();
        chk("d_empty", 64'(count_o), 0);

        // overflow: fill seq 3..10, then a fully dropped dual push
        out_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1, 32'h1000 + 32'(2 * k), 1, 32'h1001 + 32'(2 * k));
            step();
        end
        chk("o_full", 64'(count_o), 8);
        chk("o_ovf_pre", 64'(overflow_o), 0);
        drive(1, 32'hdead0, 1, 32'hdead1);
        step();
        chk("o_count", 64'(count_o), 8);
        chk("o_drop2", 64'(drop_cnt_o), 2);
        chk("o_ovf", 64'(overflow_o), 1);
        chk("o_head", 64'(out_seq_o), 3);
        // pop frees one slot: port0 lands as seq 11, port1 dropped
        drive(1, 32'h3000, 1, 32'h3001);
        out_ready_i = 1'b1;
        step();
        drive(0, 0, 0, 0);
        chk("o_pop_count", 64'(count_o), 8);
        chk("o_drop3", 64'(drop_cnt_o), 3);
        chk("o_pop_head", 64'(out_seq_o), 4);
        for (int k = 0; k < 8; k++) begin
            chk("o_drain_seq", 64'(out_seq_o), 64'(4 + k));
            if (k == 7) chk("o_last_instr", 64'(out_instr_o), 64'h3000);
            step();
        end
        chk("o_drained", 64'(count_o), 0);

        // wrap and backpressure: 20 pushes (seq 12..31) with ready toggling
        got = 0;
        exp_seq = 12;
        pv = 1'b0;
        pr = 1'b0;
        ps = '0;
        pi = '0;
        for (int c = 0; c < 60; c++) begin
            if (c % 2 == 0 && c / 2 < 20) drive(1, 32'h2000 + 32'(c / 2), 0, 0);
            else drive(0, 0, 0, 0);
            out_ready_i = c[0];
            if (pv && !pr) begin
                chk("w_hold_valid", 64'(out_valid_o), 1);
                chk("w_hold_seq", 64'(out_seq_o), 64'(ps));
                chk("w_hold_instr", 64'(out_instr_o), 64'(pi));
            end
            if (out_valid_o && out_ready_i) begin
                chk("w_seq", 64'(out_seq_o), 64'(exp_seq));
                chk("w_instr", 64'(out_instr_o), 64'(32'h2000 + 32'(exp_seq - 12)));
                exp_seq++;
                got++;
            end
            pv = out_valid_o;
            pr = out_ready_i;
            ps = out_seq_o;
            pi = out_instr_o;
            step();
        end
        drive(0, 0, 0, 0);
        chk("w_got", 64'(got), 20);
        chk("w_empty", 64'(count_o), 0);
        chk("w_drop", 64'(drop_cnt_o), 3);

        // flush at count=5 with a simultaneous push (seq 32..36 buffered)
        out_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(1, 32'h4000 + 32'(k), 0, 0);
            step();
        end
        chk("f_count5", 64'(count_o), 5);
        flush_i = 1'b1;
        drive(1, 32'h4444, 0, 0);
        out_ready_i = 1'b1;
        step();
        flush_i = 1'b0;
        drive(0, 0, 0, 0);
        out_ready_i = 1'b0;
        chk("f_count", 64'(count_o), 0);
        chk("f_valid", 64'(out_valid_o), 0);
        chk("f_ovf", 64'(overflow_o), 0);
        chk("f_drop", 64'(drop_cnt_o), 3);
        drive(1, 32'h5000, 0, 0);
        step();
        drive(0, 0, 0, 0);
        chk("f_next_seq", 64'(out_seq_o), 37);
        chk("f_next_count", 64'(count_o), 1);

        // async reset between edges
        drive(1, 32'h6000, 0, 0);
        step();
        drive(0, 0, 0, 0);
        chk("a_count_pre", 64'(count_o), 2);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("a_valid", 64'(out_valid_o), 0);
        chk("a_count", 64'(count_o), 0);
        chk("a_seq", 64'(out_seq_o), 0);
        chk("a_instr", 64'(out_instr_o), 0);
        chk("a_drop", 64'(drop_cnt_o), 0);
        step();
        rst_ni = 1'b1;
        drive(1, 32'h7000, 0, 0);
        step();
        drive(0, 0, 0, 0);
        chk("a_first_seq", 64'(out_seq_o), 0);
        chk("a_first_instr", 64'(out_instr_o), 64'h7000);
        chk("a_first_count", 64'(count_o), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
